// File: rtl/proc_core_param_if.sv
// Bus between proc_core_param and its board: instruction ROM port plus the
// OUT/halt reporting signals. Widths follow the core's DATA_W/ADDR_W.
interface proc_core_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] result;
    logic              out_valid;
    logic              halted;

    modport master (
        input  instruction,
        output address,
        output result,
        output out_valid,
        output halted
    );

    modport slave (
        output instruction,
        input  address,
        input  result,
        input  out_valid,
        input  halted
    );
endinterface

// File: rtl/proc_core_param.sv
// Multi-cycle WAIT/FETCH/EXEC/WB core with 8-entry register file and zero flag.
// Optional macro PROC_HALT_EN builds the HALT opcode and the sticky HALT state.
module proc_core_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    proc_core_param_if.master  bus
);
    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
`ifdef PROC_HALT_EN
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [3:0] OP_HALT = 4'b0111;
`endif

    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    logic [2:0]        state_q, state_d;
    logic [31:0]       div_q, div_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];
    logic [DATA_W-1:0] result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [3:0]        op_s;
    logic [2:0]        ra_s, rb_s;
    logic [7:0]        imm_s;
    logic [ADDR_W-1:0] tgt_s, pc_inc_s, npc_s;
    logic [DATA_W-1:0] ra_val_s, rb_val_s, alu_s;
    logic              wr_s;

    assign op_s     = ir_q[15:12];
    assign ra_s     = ir_q[11:9];
    assign rb_s     = ir_q[8:6];
    assign imm_s    = ir_q[7:0];
    assign tgt_s    = ir_q[ADDR_W-1:0];
    assign ra_val_s = rf_q[ra_s];
    assign rb_val_s = rf_q[rb_s];
    assign pc_inc_s = pc_q + ADDR_W'(1);
    assign wr_s     = (op_s == OP_ADDI) || (op_s == OP_ADD) || (op_s == OP_SUB);

    // Decode and ALU: result and next pc, registered in EXEC
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        npc_s = pc_inc_s;
        case (op_s)
            OP_ADDI: alu_s = ra_val_s + DATA_W'(imm_s);
            OP_ADD:  alu_s = ra_val_s + rb_val_s;
            OP_SUB:  alu_s = ra_val_s - rb_val_s;
            OP_OUT:  alu_s = ra_val_s;
            OP_JMP:  npc_s = tgt_s;
            OP_BRZ:  npc_s = zero_q ? tgt_s : pc_inc_s;
`ifdef PROC_HALT_EN
            OP_HALT: npc_s = pc_q;
`endif
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Next-state logic for the FSM, divider and all architectural state
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        alu_d       = alu_q;
        zero_d      = zero_q;
        rf_d        = rf_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (div_q == 32'(TICK_DIV - 1)) begin
                    div_d   = 32'd0;
                    state_d = S_FETCH;
                end else begin
                    div_d   = div_q + 32'd1;
                end
            end
            S_FETCH: begin
                ir_d    = bus.instruction;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d   = alu_s;
                npc_d   = npc_s;
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_WAIT;
                if (wr_s) begin
                    rf_d[ra_s] = alu_q;
                    zero_d     = (alu_q == {DATA_W{1'b0}});
                end else begin
                    zero_d     = zero_q;
                end
                if (op_s == OP_OUT) begin
                    result_d    = alu_q;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
`ifdef PROC_HALT_EN
                if (op_s == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
`ifdef PROC_HALT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_WAIT;
        endcase
    end

    // State registers; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            div_q       <= 32'd0;
            ir_q        <= 16'd0;
            pc_q        <= {ADDR_W{1'b0}};
            npc_q       <= {ADDR_W{1'b0}};
            alu_q       <= {DATA_W{1'b0}};
            zero_q      <= 1'b0;
            rf_q        <= '{default: {DATA_W{1'b0}}};
            result_q    <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            alu_q       <= alu_d;
            zero_q      <= zero_d;
            rf_q        <= rf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PROC_HALT_EN
    logic halted_q, halted_d;

    assign halted_d = halted_q || ((state_q == S_WB) && (op_s == OP_HALT));

    // Sticky halt indicator, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.address   = pc_q;
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_proc_core_param.sv
// Directed bench for proc_core_param (DATA_W=16, ADDR_W=4, TICK_DIV=1).
// Honours PROC_HALT_EN the same way as the design.
module tb_proc_core_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] rom [16];
    logic [3:0]  addr_tr [$];
    logic [15:0] res_tr [$];
    int n_checks = 0;
    int n_errors = 0;
    bit found;

    always #5 clk = ~clk;

    proc_core_param_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    assign bus.instruction = rom[bus.address];

    proc_core_param #(.DATA_W(16), .ADDR_W(4), .TICK_DIV(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_tr.size()) ? 32'(addr_tr[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] res_at(input int i);
        return (i < res_tr.size()) ? 32'(res_tr[i]) : 32'hDEAD;
    endfunction

    // Enter reset and fill the ROM with NOPs; caller then patches entries
    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        addr_tr = {bus.address};
        res_tr = {};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.out_valid) res_tr.push_back(bus.result);
            if (bus.address != addr_tr[$]) addr_tr.push_back(bus.address);
        end
    endtask

    initial begin
        // Reset state and first-WB latency
        enter_reset();
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        release_reset();
        repeat (3) @(posedge clk);
        #1 chk("addr_before_wb", 32'(bus.address), 32'd0);
        @(posedge clk);
        #1 chk("addr_after_wb", 32'(bus.address), 32'd1);

        // ALU and OUT, then BRZ not taken proves zero=0
        enter_reset();
        rom[0] = 16'h1205; rom[1] = 16'h1403; rom[2] = 16'h3280; rom[3] = 16'hF200;
        rom[4] = 16'hC009; rom[5] = 16'h8005; rom[9] = 16'h8009;
        release_reset();
        run(40);
        chk("alu_pulses", 32'(res_tr.size()), 32'd1);
        chk("alu_result", res_at(0), 32'h0002);
        chk("alu_zero_clear", 32'(bus.address), 32'd5);

        // SUB r3,r3 sets zero, BRZ taken
        enter_reset();
        rom[0] = 16'h1607; rom[1] = 16'h36C0; rom[2] = 16'hC009; rom[9] = 16'h8009;
        release_reset();
        run(30);
        chk("brz_trace_len", 32'(addr_tr.size()), 32'd4);
        chk("brz_trace1", addr_at(1), 32'd1);
        chk("brz_trace2", addr_at(2), 32'd2);
        chk("brz_trace3", addr_at(3), 32'd9);

        // ADDI clears zero, BRZ falls through
        enter_reset();
        rom[0] = 16'h1607; rom[1] = 16'h36C0; rom[2] = 16'h1601; rom[3] = 16'hC009;
        rom[4] = 16'h8004; rom[9] = 16'h8009;
        release_reset();
        run(40);
        chk("brz_nt_trace4", addr_at(4), 32'd4);
        chk("brz_nt_address", 32'(bus.address), 32'd4);

        // PC wrap from 15 to 0 with all NOPs
        enter_reset();
        release_reset();
        run(70);
        chk("wrap_15", addr_at(15), 32'd15);
        chk("wrap_0", addr_at(16), 32'd0);

        // Modulo arithmetic: 257*255 = 0xFFFF, 258*255 = 0x00FE
        enter_reset();
        rom[0] = 16'h18FF; rom[1] = 16'hF800; rom[2] = 16'h8000;
        release_reset();
        run(3200);
        chk("ovf_count", 32'(res_tr.size() >= 258), 32'd1);
        chk("ovf_257", res_at(256), 32'hFFFF);
        chk("ovf_258", res_at(257), 32'h00FE);

        // Reset during EXEC of ADDI r1,9 at pc 5
        enter_reset();
        rom[5] = 16'h1209; rom[6] = 16'hF200; rom[7] = 16'h8007;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.address == 4'd5) found = 1'b1;
        end
        chk("mid_reach_pc5", 32'(found), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("mid_address", 32'(bus.address), 32'd0);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'hF200; rom[1] = 16'h8001;
        release_reset();
        run(20);
        chk("mid_pulses", 32'(res_tr.size()), 32'd1);
        chk("mid_r1", res_at(0), 32'h0000);

        // HALT opcode
        enter_reset();
        rom[0] = 16'hF000; rom[1] = 16'h7000; rom[2] = 16'h8002;
        release_reset();
        run(120);
`ifdef PROC_HALT_EN
        chk("halt_flag", 32'(bus.halted), 32'd1);
        chk("halt_address", 32'(bus.address), 32'd1);
        chk("halt_trace_len", 32'(addr_tr.size()), 32'd2);
        chk("halt_out_valid", 32'(bus.out_valid), 32'd0);
`else
        chk("nohalt_flag", 32'(bus.halted), 32'd0);
        chk("nohalt_address", 32'(bus.address), 32'd2);
`endif
        chk("halt_out_r0", res_at(0), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/proc_core_param.md
Name: proc_core_param

Overview:
- Parametrised successor of the 4-bit-PC demo processor.
- Multi-cycle single-issue core with its own 8-entry register file, a zero flag, and a configurable instruction-rate divider.
- Fetches 16-bit instructions from an external ROM through `address`/`instruction`.
- Reports OUT-instruction values on `result` with a valid strobe.
- Sits between the board instruction ROM and the display/debug logic.

Parameters:
- DATA_W, 16: register, ALU and result width; legal range 8..32.
- ADDR_W, 4: program-counter width; ROM depth is 2^ADDR_W; legal range 1..8.
- TICK_DIV, 50000000: clk cycles spent in WAIT per instruction; minimum 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- instruction, input, 16: ROM data for `address`; combinational ROM, stable by the cycle after `address` changes.
- address, output, ADDR_W: program counter driven to the ROM.
- result, output, DATA_W: value of the last OUT instruction.
- out_valid, output, 1: one-cycle pulse when `result` is updated.
- halted, output, 1: core stopped by HALT (PROC_HALT_EN only; otherwise constant 0).

Behaviour:
- Encoding:
  - op = instr[15:12], ra = instr[11:9], rb = instr[8:6], imm = instr[7:0], tgt = instr[ADDR_W-1:0].
- Opcodes:
  - 0001 ADDI: ra <= ra + zext(imm).
  - 0010 ADD: ra <= ra + rb.
  - 0011 SUB: ra <= ra - rb.
  - 1000 JMP: pc <= tgt.
  - 1100 BRZ: pc <= tgt if zero=1, else pc+1.
  - 1111 OUT: result <= ra, out_valid pulse.
  - 0111 HALT: see Optional Feature.
  - All other opcodes: NOP.
- Arithmetic:
  - Modulo 2^DATA_W; no carry or overflow flags.
  - ADDI, ADD and SUB set zero = (written value == 0).
  - All other opcodes leave zero unchanged.
- Register file:
  - 8 x DATA_W, internal, all ordinary registers (no hard-wired R0).
  - Reads are combinational; the write happens only in WB.
- FSM states: WAIT -> FETCH -> EXEC -> WB -> WAIT.
  - WAIT: divider counts 0..TICK_DIV-1, then goes to FETCH and clears the divider.
  - FETCH: latches `instruction` into the IR.
  - EXEC: decodes the IR, reads ra/rb, and registers the ALU result and next pc.
  - WB: performs the register write, zero update, pc/`address` update, and `result`/`out_valid` update.
- Timing:
  - Instruction period is TICK_DIV+3 cycles.
  - `address` changes only on the WB edge.
  - `out_valid` is high for exactly the cycle following WB of an OUT.
- PC:
  - Default next pc = pc+1 mod 2^ADDR_W (from 2^ADDR_W-1 it wraps to 0).
  - JMP/BRZ to the current pc is legal and loops.
- Same-register operands: `ADD r1,r1` doubles r1; `SUB r1,r1` writes 0 and sets zero=1.
- Reset values:
  - address 0, result 0, out_valid 0, halted 0.
  - zero 0, all registers 0, IR 0, divider 0, state WAIT.
- Reset mid-instruction: the in-flight instruction is discarded with no register, flag or pc update; after release, execution restarts at address 0 via WAIT.

Optional Feature:
- Macro: PROC_HALT_EN.
- Defined:
  - Opcode 0111 in WB sets halted=1 and leaves pc unchanged.
  - The FSM then stays in a HALT state; `address`, registers and `result` are frozen and out_valid is 0.
  - Only rst_n exits HALT.
- Undefined:
  - 0111 executes as NOP (pc+1).
  - halted is tied to 0 and the HALT state is not built.

Test Plan:
- All Test Plan cases use DATA_W=16, ADDR_W=4, TICK_DIV=1 (period 4 cycles).
- Reset check: hold rst_n=0, then release -> address=0, result=0, out_valid=0, halted=0; the first WB occurs 4 cycles after release.
- ALU and output: ROM `ADDI r1,5; ADDI r2,3; SUB r1,r2; OUT r1` -> a single out_valid pulse with result=0x0002; zero=0 afterwards.
- Flag and branch:
  - `ADDI r3,7; SUB r3,r3; BRZ 9` at pc 0..2 -> address goes 0,1,2,9.
  - Repeat with `ADDI r3,1` between the SUB and the BRZ -> pc 3 follows the branch (not taken).
- Wrap and overflow:
  - NOPs at all 16 locations -> address goes 15 then 0.
  - `ADDI r4,255` executed 257 times -> r4 = 0xFFFF; one more execution -> r4 = 0x00FE.
- Mid-instruction reset: assert rst_n during EXEC of `ADDI r1,9` at pc 5 -> r1=0 and address=0 immediately; no out_valid.
- PROC_HALT_EN:
  - `OUT r0; HALT` -> halted=1 and address stays 1 for 100 cycles.
  - Without the macro, address advances to 2.
